// File: rtl/dallanma_cozucu_pkg.sv
// dallanma_paket: types and defaults shared by the branch resolver and its
// in-flight queue.
//   DERINLIK_VARSAYILAN : default queue depth
//   giris_t             : one in-flight prediction {ongoru, pc, hedef}
//   durum_e             : resolver state {NORMAL, TEMIZLE}
//   sonraki_pc()        : fall-through PC of a branch (pc + 4, wraps mod 2^32)
package dallanma_paket;

    localparam int DERINLIK_VARSAYILAN = 4;

    typedef struct packed {
        logic        ongoru;
        logic [31:0] pc;
        logic [31:0] hedef;
    } giris_t;

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        TEMIZLE = 1'b1
    } durum_e;

    function automatic logic [31:0] sonraki_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/dallanma_cozucu_if.sv
// dallanma_cozucu_if: prediction push, execute resolution and predictor
// feedback signals of the branch resolver.
//   slave  : resolver side (takes i_*, drives o_*)
//   master : surrounding pipeline / testbench side
interface dallanma_cozucu_if;

    // prediction push
    logic        i_ongoru_gecerli;
    logic        i_ongoru;
    logic [31:0] i_ongoru_pc;
    logic [31:0] i_ongoru_hedef;
    logic        o_ongoru_hazir;

    // execute resolution of the oldest in-flight branch
    logic        i_cozum_gecerli;
    logic        i_cozum_atladi;
    logic [31:0] i_cozum_hedef;

    // predictor feedback and redirect
    logic        o_guncelle;
    logic        o_buyruk_atladi;
    logic        o_ongoru_yanlis;
    logic [31:0] o_duzeltme_pc;

    // status
    logic        o_bos;
    logic        o_dolu;
    logic [15:0] o_yanlis_sayaci;

    modport slave (
        input  i_ongoru_gecerli, i_ongoru, i_ongoru_pc, i_ongoru_hedef,
        input  i_cozum_gecerli, i_cozum_atladi, i_cozum_hedef,
        output o_ongoru_hazir, o_guncelle, o_buyruk_atladi, o_ongoru_yanlis,
        output o_duzeltme_pc, o_bos, o_dolu, o_yanlis_sayaci
    );

    modport master (
        output i_ongoru_gecerli, i_ongoru, i_ongoru_pc, i_ongoru_hedef,
        output i_cozum_gecerli, i_cozum_atladi, i_cozum_hedef,
        input  o_ongoru_hazir, o_guncelle, o_buyruk_atladi, o_ongoru_yanlis,
        input  o_duzeltme_pc, o_bos, o_dolu, o_yanlis_sayaci
    );

endinterface

// File: rtl/dallanma_cozucu_ongoru_fifo.sv
// ongoru_fifo: circular queue of in-flight predicted branches.
//   i_saat, i_reset : clock, async active-low reset
//   i_it, i_veri    : push request and entry (refused when full or clearing)
//   i_cek           : pop oldest entry (ignored when empty)
//   i_temizle       : drop every entry; wins over a same-cycle push/pop
//   o_dolu, o_bos   : occupancy == DERINLIK / == 0
//   o_bas           : oldest entry (undefined when empty)
module ongoru_fifo
    import dallanma_paket::*;
#(
    parameter int DERINLIK = DERINLIK_VARSAYILAN
) (
    input  logic   i_saat,
    input  logic   i_reset,
    input  logic   i_it,
    input  giris_t i_veri,
    input  logic   i_cek,
    input  logic   i_temizle,
    output logic   o_dolu,
    output logic   o_bos,
    output giris_t o_bas
);

    localparam int PW = $clog2(DERINLIK);
    localparam logic [PW:0] DOLU_SAYI = DERINLIK[PW:0];

    logic [PW-1:0] yaz_q, oku_q;
    logic [PW:0]   sayi_q;
    giris_t        bellek [DERINLIK];

    logic it_gec, cek_gec;

    assign o_dolu  = (sayi_q == DOLU_SAYI);
    assign o_bos   = (sayi_q == '0);
    assign it_gec  = i_it && !o_dolu && !i_temizle;
    assign cek_gec = i_cek && !o_bos && !i_temizle;
    assign o_bas   = bellek[oku_q];

    // depth is a power of two, so pointer increment wraps naturally
    always_ff @(posedge i_saat or negedge i_reset) begin
        if (!i_reset) begin
            yaz_q  <= '0;
            oku_q  <= '0;
            sayi_q <= '0;
        end else if (i_temizle) begin
            yaz_q  <= '0;
            oku_q  <= '0;
            sayi_q <= '0;
        end else begin
            if (it_gec)  yaz_q <= yaz_q + 1'b1;
            if (cek_gec) oku_q <= oku_q + 1'b1;
            sayi_q <= sayi_q + {{PW{1'b0}}, it_gec} - {{PW{1'b0}}, cek_gec};
        end
    end

    // storage is not reset; occupancy alone decides what is valid
    always_ff @(posedge i_saat) begin
        if (it_gec) bellek[yaz_q] <= i_veri;
    end

endmodule

// File: rtl/dallanma_cozucu.sv
// dallanma_cozucu: holds in-flight predicted branches, checks the oldest one
// against the execute-stage outcome and reports the real direction back to
// the gshare predictor. A misprediction flushes the queue and costs one
// TEMIZLE cycle in which nothing is accepted.
//   i_saat, i_reset : clock, async active-low reset
//   bus (slave)     : push (i_ongoru_*), resolve (i_cozum_*), registered
//                     pulses o_guncelle/o_buyruk_atladi/o_ongoru_yanlis,
//                     redirect o_duzeltme_pc, status o_bos/o_dolu, and the
//                     saturating o_yanlis_sayaci
module dallanma_cozucu
    import dallanma_paket::*;
#(
    parameter int DERINLIK = DERINLIK_VARSAYILAN
) (
    input  logic               i_saat,
    input  logic               i_reset,
    dallanma_cozucu_if.slave   bus
);

    localparam logic [0:0] S_NORMAL  = NORMAL;
    localparam logic [0:0] S_TEMIZLE = TEMIZLE;

    logic [0:0]  durum_q;
    logic        guncelle_q, atladi_q, yanlis_q;
    logic [31:0] duzeltme_q;
    logic [15:0] yanlis_sayaci_q;

    logic   dolu, bos, hazir, it, cek, yanlis, temizle;
    giris_t bas, yeni;
    logic [31:0] duzeltme_pc;

    // ready is gated by reset so it stays low while reset is held
    assign hazir = i_reset && (durum_q == S_NORMAL) && !dolu;
    assign it    = bus.i_ongoru_gecerli && hazir;
    assign cek   = bus.i_cozum_gecerli && !bos && (durum_q == S_NORMAL);

    assign yeni.ongoru = bus.i_ongoru;
    assign yeni.pc     = bus.i_ongoru_pc;
    assign yeni.hedef  = bus.i_ongoru_hedef;

    // wrong direction, or right "taken" direction with the wrong target
    assign yanlis = (bas.ongoru != bus.i_cozum_atladi) ||
                    (bas.ongoru && bus.i_cozum_atladi &&
                     (bas.hedef != bus.i_cozum_hedef));
    assign temizle = cek && yanlis;

    assign duzeltme_pc = bus.i_cozum_atladi ? bus.i_cozum_hedef
                                            : sonraki_pc(bas.pc);

    ongoru_fifo #(.DERINLIK(DERINLIK)) u_fifo (
        .i_saat    (i_saat),
        .i_reset   (i_reset),
        .i_it      (it),
        .i_veri    (yeni),
        .i_cek     (cek),
        .i_temizle (temizle),
        .o_dolu    (dolu),
        .o_bos     (bos),
        .o_bas     (bas)
    );

    always_ff @(posedge i_saat or negedge i_reset) begin
        if (!i_reset) begin
            durum_q <= S_NORMAL;
        end else begin
            case (durum_q)
                S_NORMAL:  if (temizle) durum_q <= S_TEMIZLE;
                S_TEMIZLE: durum_q <= S_NORMAL;
                default:   durum_q <= S_NORMAL;
            endcase
        end
    end

    always_ff @(posedge i_saat or negedge i_reset) begin
        if (!i_reset) begin
            guncelle_q      <= 1'b0;
            atladi_q        <= 1'b0;
            yanlis_q        <= 1'b0;
            duzeltme_q      <= 32'h0;
            yanlis_sayaci_q <= 16'h0;
        end else begin
            guncelle_q <= cek;
            atladi_q   <= cek && bus.i_cozum_atladi;
            yanlis_q   <= temizle;
            if (temizle) begin
                duzeltme_q <= duzeltme_pc;
                if (yanlis_sayaci_q != 16'hFFFF)
                    yanlis_sayaci_q <= yanlis_sayaci_q + 16'd1;
            end
        end
    end

    assign bus.o_ongoru_hazir  = hazir;
    assign bus.o_guncelle      = guncelle_q;
    assign bus.o_buyruk_atladi = atladi_q;
    assign bus.o_ongoru_yanlis = yanlis_q;
    assign bus.o_duzeltme_pc   = duzeltme_q;
    assign bus.o_bos           = bos;
    assign bus.o_dolu          = dolu;
    assign bus.o_yanlis_sayaci = yanlis_sayaci_q;

endmodule

// File: tb/tb_dallanma_cozucu.sv
// Directed bench for dallanma_cozucu (DERINLIK = 4). Inputs change #1 after
// a rising edge; outputs are sampled at the same point, so a registered pulse
// caused by edge N is seen right after tick() returns from edge N.
module tb_dallanma_cozucu;

    logic i_saat  = 1'b0;
    logic i_reset = 1'b0;

    dallanma_cozucu_if bus();

    dallanma_cozucu #(.DERINLIK(4)) dut (
        .i_saat  (i_saat),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_saat = ~i_saat;

    int n_top = 0;
    int n_gec = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_top++;
        assert (obs === exp) n_gec++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_top++;
        assert (obs === exp) n_gec++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_saat);
        #1;
    endtask

    task automatic push(input logic o, input logic [31:0] pc, input logic [31:0] h);
        bus.i_ongoru_gecerli = 1'b1;
        bus.i_ongoru         = o;
        bus.i_ongoru_pc      = pc;
        bus.i_ongoru_hedef   = h;
        tick();
        bus.i_ongoru_gecerli = 1'b0;
    endtask

    task automatic resolve(input logic a, input logic [31:0] h);
        bus.i_cozum_gecerli = 1'b1;
        bus.i_cozum_atladi  = a;
        bus.i_cozum_hedef   = h;
        tick();
        bus.i_cozum_gecerli = 1'b0;
    endtask

    logic        e_o [4];
    logic [31:0] e_pc [4];
    logic [31:0] e_h [4];

    initial begin
        bus.i_ongoru_gecerli = 1'b0;
        bus.i_ongoru         = 1'b0;
        bus.i_ongoru_pc      = 32'h0;
        bus.i_ongoru_hedef   = 32'h0;
        bus.i_cozum_gecerli  = 1'b0;
        bus.i_cozum_atladi   = 1'b0;
        bus.i_cozum_hedef    = 32'h0;

        // ---- reset state
        #1;
        chk1 ("rst_bos",      bus.o_bos, 1'b1);
        chk1 ("rst_dolu",     bus.o_dolu, 1'b0);
        chk1 ("rst_hazir",    bus.o_ongoru_hazir, 1'b0);
        chk1 ("rst_guncelle", bus.o_guncelle, 1'b0);
        chk1 ("rst_yanlis",   bus.o_ongoru_yanlis, 1'b0);
        chk32("rst_duz",      bus.o_duzeltme_pc, 32'h0);
        chk32("rst_sayac",    {16'h0, bus.o_yanlis_sayaci}, 32'h0);
        tick();
        tick();
        i_reset = 1'b1;
        #1;
        chk1 ("rls_hazir", bus.o_ongoru_hazir, 1'b1);

        // ---- correct taken prediction
        push(1'b1, 32'h100, 32'h200);
        chk1 ("t1_bos0", bus.o_bos, 1'b0);
        resolve(1'b1, 32'h200);
        chk1 ("t1_guncelle", bus.o_guncelle, 1'b1);
        chk1 ("t1_atladi",   bus.o_buyruk_atladi, 1'b1);
        chk1 ("t1_yanlis",   bus.o_ongoru_yanlis, 1'b0);
        chk1 ("t1_bos",      bus.o_bos, 1'b1);
        tick();
        chk1 ("t1_pulse_end", bus.o_guncelle, 1'b0);

        // ---- predicted not-taken, actually taken
        push(1'b0, 32'h104, 32'h0);
        resolve(1'b1, 32'h180);
        chk1 ("t2_yanlis", bus.o_ongoru_yanlis, 1'b1);
        chk32("t2_duz",    bus.o_duzeltme_pc, 32'h180);
        chk32("t2_sayac",  {16'h0, bus.o_yanlis_sayaci}, 32'h1);
        chk1 ("t2_hazir0", bus.o_ongoru_hazir, 1'b0);
        chk1 ("t2_bos",    bus.o_bos, 1'b1);
        // push offered during the flush cycle must be ignored
        bus.i_ongoru_gecerli = 1'b1;
        bus.i_ongoru_pc      = 32'h1F0;
        tick();
        chk1 ("t2_hazir1",    bus.o_ongoru_hazir, 1'b1);
        bus.i_ongoru_gecerli = 1'b0;
        chk1 ("t2_flush_push", bus.o_bos, 1'b1);
        chk1 ("t2_pulse_end", bus.o_ongoru_yanlis, 1'b0);

        // ---- predicted taken, actually not taken
        push(1'b1, 32'h108, 32'h300);
        resolve(1'b0, 32'h0);
        chk1 ("t3_yanlis", bus.o_ongoru_yanlis, 1'b1);
        chk1 ("t3_atladi", bus.o_buyruk_atladi, 1'b0);
        chk32("t3_duz",    bus.o_duzeltme_pc, 32'h10C);
        chk32("t3_sayac",  {16'h0, bus.o_yanlis_sayaci}, 32'h2);
        tick();

        // ---- fill, overflow attempt, drain in order
        for (int i = 0; i < 4; i++) begin
            e_o[i]  = 1'(i % 2);
            e_pc[i] = 32'h200 + 32'(4 * i);
            e_h[i]  = 32'h400 + 32'(16 * i);
            push(e_o[i], e_pc[i], e_h[i]);
        end
        chk1 ("t4_dolu",  bus.o_dolu, 1'b1);
        chk1 ("t4_hazir", bus.o_ongoru_hazir, 1'b0);
        push(1'b1, 32'h2F0, 32'h2F0);
        chk1 ("t4_dolu5", bus.o_dolu, 1'b1);
        for (int i = 0; i < 4; i++) begin
            // push offered with the first pop: still refused (full)
            bus.i_ongoru_gecerli = (i == 0);
            bus.i_ongoru         = 1'b1;
            bus.i_ongoru_pc      = 32'h2F4;
            bus.i_ongoru_hedef   = 32'h2F4;
            resolve(e_o[i], e_o[i] ? e_h[i] : 32'h0);
            bus.i_ongoru_gecerli = 1'b0;
            chk1 ($sformatf("t4_g%0d", i), bus.o_guncelle, 1'b1);
            chk1 ($sformatf("t4_a%0d", i), bus.o_buyruk_atladi, e_o[i]);
            chk1 ($sformatf("t4_y%0d", i), bus.o_ongoru_yanlis, 1'b0);
        end
        chk1 ("t4_bos", bus.o_bos, 1'b1);
        tick();
        chk1 ("t4_quiet", bus.o_guncelle, 1'b0);

        // ---- second round: offset pointers so the next fill wraps
        push(1'b1, 32'h700, 32'h710);
        push(1'b1, 32'h704, 32'h714);
        resolve(1'b1, 32'h710);
        resolve(1'b1, 32'h714);
        chk1 ("t5_pre_y", bus.o_ongoru_yanlis, 1'b0);
        for (int i = 0; i < 4; i++) begin
            e_o[i]  = 1'((i + 1) % 2);
            e_pc[i] = 32'h800 + 32'(4 * i);
            e_h[i]  = 32'h900 + 32'(8 * i);
            push(e_o[i], e_pc[i], e_h[i]);
        end
        chk1 ("t5_dolu", bus.o_dolu, 1'b1);
        for (int i = 0; i < 4; i++) begin
            resolve(e_o[i], e_o[i] ? e_h[i] : 32'h0);
            chk1 ($sformatf("t5_a%0d", i), bus.o_buyruk_atladi, e_o[i]);
            chk1 ($sformatf("t5_y%0d", i), bus.o_ongoru_yanlis, 1'b0);
        end
        chk1 ("t5_bos", bus.o_bos, 1'b1);

        // ---- mispredict with 3 queued and a same-cycle push
        for (int i = 0; i < 3; i++)
            push(1'b1, 32'h500 + 32'(4 * i), 32'h600 + 32'(4 * i));
        bus.i_ongoru_gecerli = 1'b1;
        bus.i_ongoru         = 1'b1;
        bus.i_ongoru_pc      = 32'h5F0;
        bus.i_ongoru_hedef   = 32'h5F0;
        resolve(1'b0, 32'h0);
        bus.i_ongoru_gecerli = 1'b0;
        chk1 ("t6_yanlis", bus.o_ongoru_yanlis, 1'b1);
        chk1 ("t6_bos",    bus.o_bos, 1'b1);
        chk32("t6_duz",    bus.o_duzeltme_pc, 32'h504);
        chk32("t6_sayac",  {16'h0, bus.o_yanlis_sayaci}, 32'h3);
        bus.i_cozum_gecerli = 1'b1;
        bus.i_cozum_atladi  = 1'b1;
        bus.i_cozum_hedef   = 32'h5F0;
        tick();
        chk1 ("t6_nop1", bus.o_guncelle, 1'b0);
        tick();
        chk1 ("t6_nop2", bus.o_guncelle, 1'b0);
        chk1 ("t6_bos2", bus.o_bos, 1'b1);
        bus.i_cozum_gecerli = 1'b0;

        // ---- asynchronous reset with two entries in flight
        for (int i = 0; i < 3; i++)
            push(1'b1, 32'hA00 + 32'(4 * i), 32'hB00 + 32'(4 * i));
        resolve(1'b1, 32'hB00);
        chk1 ("t7_pre_g", bus.o_guncelle, 1'b1);
        #2;
        i_reset = 1'b0;
        #1;
        chk1 ("t7_g",     bus.o_guncelle, 1'b0);
        chk1 ("t7_a",     bus.o_buyruk_atladi, 1'b0);
        chk32("t7_duz",   bus.o_duzeltme_pc, 32'h0);
        chk32("t7_sayac", {16'h0, bus.o_yanlis_sayaci}, 32'h0);
        chk1 ("t7_bos",   bus.o_bos, 1'b1);
        chk1 ("t7_hazir", bus.o_ongoru_hazir, 1'b0);
        #2;
        i_reset = 1'b1;
        resolve(1'b1, 32'hB04);
        chk1 ("t7_post_g", bus.o_guncelle, 1'b0);
        chk1 ("t7_post_y", bus.o_ongoru_yanlis, 1'b0);
        chk1 ("t7_post_b", bus.o_bos, 1'b1);

        // ---- counter saturation (preloaded near the top)
        force dut.yanlis_sayaci_q = 16'hFFFE;
        #1;
        release dut.yanlis_sayaci_q;
        push(1'b0, 32'hC00, 32'h0);
        resolve(1'b1, 32'hD00);
        chk32("t8_ffff", {16'h0, bus.o_yanlis_sayaci}, 32'hFFFF);
        tick();
        push(1'b0, 32'hC04, 32'h0);
        resolve(1'b1, 32'hD04);
        chk1 ("t8_yanlis", bus.o_ongoru_yanlis, 1'b1);
        chk32("t8_duz",    bus.o_duzeltme_pc, 32'hD04);
        chk32("t8_hold",   {16'h0, bus.o_yanlis_sayaci}, 32'hFFFF);
        tick();

        $display("%0d/%0d checks passed", n_gec, n_top);
        $finish;
    end

endmodule
